// File: rtl/exu_lsu_pkg.sv
// Shared constants for the load/store unit: ISA width, access size codes,
// completion error codes and the access sequencer state encoding.
package exu_lsu_pkg;

  localparam int ISA_WIDTH = 32;

  // Access size codes carried on req_size
  localparam logic [1:0] SIZE_BYTE   = 2'd0;
  localparam logic [1:0] SIZE_HALF   = 2'd1;
  localparam logic [1:0] SIZE_WORD   = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  // Completion error codes carried on resp_err
  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_SIZE     = 2'd3;

  // Access sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic shared by the store and load paths: store data
// lane shift and byte strobes, access legality checks, and load data
// extraction with sign/zero extension.
module lsu_align
  import exu_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFFW       = $clog2(DATA_WIDTH / 8)
) (
  input  logic [1:0]              st_size,
  input  logic [OFFW-1:0]         st_offset,
  input  logic [DATA_WIDTH-1:0]   st_wdata,
  output logic [DATA_WIDTH-1:0]   st_data,
  output logic [DATA_WIDTH/8-1:0] st_strb,
  output logic                    misaligned,
  output logic                    illegal,
  input  logic [1:0]              ld_size,
  input  logic [OFFW-1:0]         ld_offset,
  input  logic                    ld_unsigned,
  input  logic [DATA_WIDTH-1:0]   ld_rdata,
  output logic [DATA_WIDTH-1:0]   ld_data
);

  localparam int NB = DATA_WIDTH / 8;

  logic [NB-1:0]         strb_base;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] mask;
  logic                  sign;

  // Store side: move data into its byte lanes and build the strobe mask
  always_comb begin
    st_data = st_wdata << {st_offset, 3'b000};
    case (st_size)
      SIZE_BYTE: strb_base = {NB{1'b1}} >> (NB - 1);
      SIZE_HALF: strb_base = {NB{1'b1}} >> (NB - 2);
      SIZE_WORD: strb_base = {NB{1'b1}} >> (NB - 4);
      default:   strb_base = {NB{1'b1}};
    endcase
    st_strb = strb_base << st_offset;
  end

  // Legality: double only exists on a 64-bit datapath; address must be size-aligned
  always_comb begin
    illegal = (st_size == SIZE_DOUBLE) && (DATA_WIDTH != 64);
    case (st_size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = st_offset[0];
      SIZE_WORD: misaligned = |st_offset[1:0];
      default:   misaligned = |st_offset;
    endcase
  end

  // Load side: bring the addressed bytes down to bit 0, keep the access width, extend
  always_comb begin
    shifted = ld_rdata >> {ld_offset, 3'b000};
    case (ld_size)
      SIZE_BYTE: begin
        mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 8);
        sign = shifted[7];
      end
      SIZE_HALF: begin
        mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 16);
        sign = shifted[15];
      end
      SIZE_WORD: begin
        mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 32);
        sign = shifted[31];
      end
      default: begin
        mask = {DATA_WIDTH{1'b1}};
        sign = shifted[DATA_WIDTH-1];
      end
    endcase
    if (!ld_unsigned && sign) begin
      ld_data = (shifted & mask) | ~mask;
    end else begin
      ld_data = shifted & mask;
    end
  end

endmodule

// File: rtl/exu_lsu.sv
// Load/store unit: accepts one access at a time, rejects illegal or
// misaligned accesses without touching the bus, performs a single bus
// beat with a wait timeout, and returns an extended load result or a
// store acknowledge through a held response.
module exu_lsu
  import exu_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [1:0]              resp_err
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = $clog2(TIMEOUT + 1);

  lsu_state_t state;
  lsu_state_t state_next;

  logic [CNTW-1:0]       cnt;
  logic [CNTW-1:0]       cnt_next;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [OFFW-1:0]       off_q;

  logic                  accept;
  logic                  timeout_hit;
  logic                  resp_load;
  logic [1:0]            resp_err_next;
  logic [DATA_WIDTH-1:0] resp_rdata_next;

  logic [DATA_WIDTH-1:0] st_data;
  logic [NB-1:0]         st_strb;
  logic                  misaligned;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] ld_data;

  assign accept      = req_valid && req_ready;
  assign timeout_hit = (cnt == CNTW'(TIMEOUT - 1));

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFFW       (OFFW)
  ) u_align (
    .st_size     (req_size),
    .st_offset   (req_addr[OFFW-1:0]),
    .st_wdata    (req_wdata),
    .st_data     (st_data),
    .st_strb     (st_strb),
    .misaligned  (misaligned),
    .illegal     (illegal),
    .ld_size     (size_q),
    .ld_offset   (off_q),
    .ld_unsigned (uns_q),
    .ld_rdata    (mem_rdata),
    .ld_data     (ld_data)
  );

  // Next-state, wait counter and completion selection
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    resp_load       = 1'b0;
    resp_err_next   = ERR_OK;
    resp_rdata_next = {DATA_WIDTH{1'b0}};
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (illegal) begin
            state_next    = S_RESP;
            resp_load     = 1'b1;
            resp_err_next = ERR_SIZE;
          end else if (misaligned) begin
            state_next    = S_RESP;
            resp_load     = 1'b1;
            resp_err_next = ERR_MISALIGN;
          end else begin
            state_next = S_BUS;
            cnt_next   = {CNTW{1'b0}};
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_BUS: begin
        cnt_next = cnt + CNTW'(1);
        if (mem_ready && mem_rvalid) begin
          state_next      = S_RESP;
          resp_load       = 1'b1;
          resp_rdata_next = mem_we ? {DATA_WIDTH{1'b0}} : ld_data;
        end else if (timeout_hit) begin
          state_next    = S_RESP;
          resp_load     = 1'b1;
          resp_err_next = ERR_TIMEOUT;
        end else if (mem_ready) begin
          state_next = S_WAIT;
        end else begin
          state_next = S_BUS;
        end
      end
      S_WAIT: begin
        cnt_next = cnt + CNTW'(1);
        if (mem_rvalid) begin
          state_next      = S_RESP;
          resp_load       = 1'b1;
          resp_rdata_next = mem_we ? {DATA_WIDTH{1'b0}} : ld_data;
        end else if (timeout_hit) begin
          state_next    = S_RESP;
          resp_load     = 1'b1;
          resp_err_next = ERR_TIMEOUT;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_RESP;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register, counter and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= {CNTW{1'b0}};
      req_ready  <= 1'b1;
      mem_valid  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      req_ready  <= (state_next == S_IDLE);
      mem_valid  <= (state_next == S_BUS);
      resp_valid <= (state_next == S_RESP);
    end
  end

  // Capture the request and its lane-aligned bus image on acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      size_q    <= SIZE_BYTE;
      uns_q     <= 1'b0;
      off_q     <= {OFFW{1'b0}};
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_WIDTH{1'b0}};
      mem_wdata <= {DATA_WIDTH{1'b0}};
      mem_wstrb <= {NB{1'b0}};
    end else if (accept) begin
      size_q    <= req_size;
      uns_q     <= req_unsigned;
      off_q     <= req_addr[OFFW-1:0];
      mem_we    <= req_we;
      mem_addr  <= {req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
      mem_wdata <= req_we ? st_data : {DATA_WIDTH{1'b0}};
      mem_wstrb <= req_we ? st_strb : {NB{1'b0}};
    end else begin
      size_q    <= size_q;
      uns_q     <= uns_q;
      off_q     <= off_q;
      mem_we    <= mem_we;
      mem_addr  <= mem_addr;
      mem_wdata <= mem_wdata;
      mem_wstrb <= mem_wstrb;
    end
  end

  // Completion data and error code, held while the response waits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_rdata <= {DATA_WIDTH{1'b0}};
      resp_err   <= ERR_OK;
    end else if (resp_load) begin
      resp_rdata <= resp_rdata_next;
      resp_err   <= resp_err_next;
    end else begin
      resp_rdata <= resp_rdata;
      resp_err   <= resp_err;
    end
  end

endmodule

// File: tb/tb_exu_lsu.sv
// Self-checking bench for exu_lsu: directed and randomized accesses against
// an arithmetic reference model, plus timeout and reset-abandon scenarios.
module tb_exu_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid_t = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic        mem_ready_t = 1'b0, mem_rvalid_t = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        resp_ready = 1'b0, resp_ready_t = 1'b0;

  logic        req_ready, mem_valid, mem_we, resp_valid;
  logic [31:0] mem_addr, mem_wdata, resp_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  resp_err;

  logic        req_ready_t, mem_valid_t, mem_we_t, resp_valid_t;
  logic [31:0] mem_addr_t, mem_wdata_t, resp_rdata_t;
  logic [3:0]  mem_wstrb_t;
  logic [1:0]  resp_err_t;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exu_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  exu_lsu #(.TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .req_valid(req_valid_t), .req_ready(req_ready_t),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_valid(mem_valid_t),
    .mem_ready(mem_ready_t), .mem_we(mem_we_t), .mem_addr(mem_addr_t),
    .mem_wdata(mem_wdata_t), .mem_wstrb(mem_wstrb_t), .mem_rvalid(mem_rvalid_t),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid_t), .resp_ready(resp_ready_t),
    .resp_rdata(resp_rdata_t), .resp_err(resp_err_t)
  );

  // Reference: what the bus and the completion must look like for one access
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, output logic [1:0] err,
                                output logic [31:0] maddr, output logic [31:0] mwdata,
                                output logic [3:0] mstrb, output logic [31:0] rd);
    int bytes;
    int off;
    logic [63:0] w;
    longint v;
    longint span;
    bytes = 1 << sz;
    off = int'(addr % 32'd4);
    if (sz == 2'd3) err = 2'd3;
    else if ((addr % bytes) != 0) err = 2'd1;
    else err = 2'd0;
    maddr = addr - 32'(off);
    w = {32'd0, wdata} << (8 * off);
    mwdata = w[31:0];
    mstrb = we ? 4'(((1 << bytes) - 1) << off) : 4'd0;
    rd = 32'd0;
    if (!we && err == 2'd0) begin
      span = longint'(1) << (8 * bytes);
      v = longint'(rdata >> (8 * off)) % span;
      if (!uns && v >= span / 2) v = v - span;
      rd = 32'(v);
    end
  endfunction

  // One complete access on dut with chosen bus-ready, read-valid and response delays
  task automatic do_access(input string name, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int rdly, input int vdly, input int pdly);
    logic [1:0] e_err;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0] e_strb;
    model(we, sz, uns, addr, wdata, rdata, e_err, e_addr, e_wdata, e_strb, e_rd);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready_at_start: req_ready=%b expected 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom_range(0, 3));
    if (e_err == 2'd0) begin
      for (int c = 0; c <= rdly; c++) begin
        checks++;
        if (mem_valid !== 1'b1 || mem_we !== we || mem_addr !== e_addr || mem_wstrb !== e_strb ||
            (we && mem_wdata !== e_wdata) || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s bus_cycle%0d: valid=%b we=%b addr=%h strb=%b wdata=%h rv=%b expected 1 %b %h %b %h 0",
                   name, c, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, resp_valid,
                   we, e_addr, e_strb, e_wdata);
        end
        if (c == rdly) begin
          mem_ready = 1'b1;
          if (vdly == 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
        end
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
      for (int c = 1; c <= vdly; c++) begin
        checks++;
        if (mem_valid !== 1'b0 || resp_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s wait_cycle%0d: mem_valid=%b resp_valid=%b expected 0 0", name, c, mem_valid, resp_valid);
        end
        if (c == vdly) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
    end
    for (int c = 0; c <= pdly; c++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== e_err || resp_rdata !== e_rd ||
          mem_valid !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s resp_cycle%0d: valid=%b err=%0d rdata=%h mem_valid=%b expected 1 %0d %h 0",
                 name, c, resp_valid, resp_err, resp_rdata, mem_valid, e_err, e_rd);
      end
      if (c == pdly) resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s single_completion: resp_valid=%b req_ready=%b expected 0 1", name, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0) begin
      failures++; $display("FAIL reset_bus: ready=%b mvalid=%b we=%b addr=%h expected 1 0 0 0",
                           req_ready, mem_valid, mem_we, mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'd0 || mem_wstrb !== 4'd0) begin
      failures++; $display("FAIL reset_wdata: wdata=%h strb=%b expected 0 0", mem_wdata, mem_wstrb);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 2'd0) begin
      failures++; $display("FAIL reset_resp: valid=%b rdata=%h err=%0d expected 0 0 0",
                           resp_valid, resp_rdata, resp_err);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_access("load_byte_signed", 1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 0, 0, 0);
    do_access("store_half", 1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 0, 0, 0);
    do_access("misaligned_word", 1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0);
    do_access("illegal_double", 1'b0, 2'd3, 1'b1, 32'h8000_0008, 32'h0, 32'h0, 0, 0, 1);
    do_access("load_half_zext", 1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0, 32'hF00D_8001, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    do_access("backpressure_load", 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 1, 2);
    do_access("backpressure_store", 1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_00A5, 32'h0, 3, 2, 2);
  endtask

  task automatic test_back_to_back();
    do_access("b2b_first", 1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 0, 0, 0);
    do_access("b2b_second", 1'b0, 2'd0, 1'b1, 32'h0000_0202, 32'h0, 32'h00C3_0000, 0, 0, 0);
  endtask

  task automatic test_random();
    logic we, uns;
    logic [1:0] sz;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      do_access($sformatf("rand%0d", i), we, sz, uns, addr, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  task automatic test_timeout();
    req_valid_t = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0000_0040;
    @(posedge clk); #1;
    req_valid_t = 1'b0;
    checks++;
    if (mem_valid_t !== 1'b1) begin
      failures++; $display("FAIL timeout_bus: mem_valid=%b expected 1", mem_valid_t);
    end
    mem_ready_t = 1'b1;
    @(posedge clk); #1;
    mem_ready_t = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (resp_valid_t !== 1'b0 || mem_valid_t !== 1'b0) begin
        failures++; $display("FAIL timeout_wait%0d: resp_valid=%b mem_valid=%b expected 0 0", c, resp_valid_t, mem_valid_t);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (resp_valid_t !== 1'b1 || resp_err_t !== 2'd2 || resp_rdata_t !== 32'd0) begin
      failures++; $display("FAIL timeout_resp: valid=%b err=%0d rdata=%h expected 1 2 0",
                           resp_valid_t, resp_err_t, resp_rdata_t);
    end
    mem_rvalid_t = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_rvalid_t = 1'b0;
    checks++;
    if (resp_valid_t !== 1'b1 || resp_err_t !== 2'd2 || resp_rdata_t !== 32'd0) begin
      failures++; $display("FAIL timeout_late_beat: valid=%b err=%0d rdata=%h expected 1 2 0",
                           resp_valid_t, resp_err_t, resp_rdata_t);
    end
    resp_ready_t = 1'b1;
    @(posedge clk); #1;
    resp_ready_t = 1'b0;
    mem_rvalid_t = 1'b1;
    @(posedge clk); #1;
    mem_rvalid_t = 1'b0;
    checks++;
    if (resp_valid_t !== 1'b0 || req_ready_t !== 1'b1 || mem_valid_t !== 1'b0) begin
      failures++; $display("FAIL timeout_idle: resp_valid=%b req_ready=%b mem_valid=%b expected 0 1 0",
                           resp_valid_t, req_ready_t, mem_valid_t);
    end
  endtask

  task automatic test_reset_in_wait();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0000_0080;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checks++;
    if (mem_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++; $display("FAIL rst_wait_entry: mem_valid=%b resp_valid=%b req_ready=%b expected 0 0 0",
                           mem_valid, resp_valid, req_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_valid !== 1'b0 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_async: req_ready=%b mem_valid=%b resp_valid=%b expected 1 0 0",
                           req_ready, mem_valid, resp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_late_beat: resp_valid=%b req_ready=%b expected 0 1", resp_valid, req_ready);
    end
    do_access("after_reset", 1'b0, 2'd1, 1'b0, 32'h0000_0086, 32'h0, 32'h8765_4321, 0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_lsu.md
EXU_LSU -- requirements
Module: exu_lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data width in bits: 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the address width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of memory-wait cycles before an error response.
REQ-004 Port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port req_valid, input, 1 bit: an access request is present.
REQ-007 Port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-008 Port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 Port req_size, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = double (double legal only when DATA_WIDTH = 64).
REQ-010 Port req_unsigned, input, 1 bit: load zero-extends when 1, sign-extends when 0.
REQ-011 Port req_addr, input, ADDR_WIDTH bits: byte address.
REQ-012 Port req_wdata, input, DATA_WIDTH bits: store data, right-aligned.
REQ-013 Port mem_valid, output, 1 bit: bus request.
REQ-014 Port mem_ready, input, 1 bit: the bus accepts the request.
REQ-015 Port mem_we, output, 1 bit: bus write.
REQ-016 Port mem_addr, output, ADDR_WIDTH bits: address aligned down to DATA_WIDTH/8 bytes.
REQ-017 Port mem_wdata, output, DATA_WIDTH bits: lane-shifted store data.
REQ-018 Port mem_wstrb, output, DATA_WIDTH/8 bits: byte write strobes.
REQ-019 Port mem_rvalid, input, 1 bit: read data, or the write acknowledge, is valid.
REQ-020 Port mem_rdata, input, DATA_WIDTH bits: read data.
REQ-021 Port resp_valid, output, 1 bit: a completion is present.
REQ-022 Port resp_ready, input, 1 bit: the consumer takes the completion.
REQ-023 Port resp_rdata, output, DATA_WIDTH bits: extended load result; 0 for stores.
REQ-024 Port resp_err, output, 2 bits: 0 = ok, 1 = misaligned, 2 = timeout, 3 = illegal size.

Function
REQ-025 SHALL implement the FSM states IDLE, BUS, WAIT and RESP.
REQ-026 IDLE: req_ready=1; the request is captured when req_valid&&req_ready, with all request fields registered.
REQ-027 From IDLE with a captured request: if misaligned (addr mod size-bytes ≠ 0) or illegal size, SHALL go to RESP with the error code set, no bus access, and mem_valid never asserted.
REQ-028 From IDLE with a legal captured request, SHALL go to BUS.
REQ-029 BUS: mem_valid=1 and the bus outputs are held stable until mem_ready; on mem_ready, SHALL go to WAIT.
REQ-030 If mem_rvalid arrives together with mem_ready, SHALL go directly to RESP.
REQ-031 WAIT: on mem_rvalid, SHALL latch the extended data and go to RESP.
REQ-032 A cycle counter SHALL run in BUS and WAIT; when the count reaches TIMEOUT, SHALL go to RESP with err=2 and resp_rdata=0.
REQ-033 A late mem_rvalid that arrives after a timeout SHALL be ignored.
REQ-034 RESP: resp_valid=1 and resp_rdata/resp_err are held until resp_ready; then SHALL return to IDLE.
REQ-035 req_ready=0 outside IDLE; there is no back-to-back overlap, so throughput is at most one access per 3 cycles.
REQ-036 Minimum latency, acceptance to resp_valid, SHALL be 2 cycles (mem_ready and mem_rvalid both seen in the first BUS cycle).
REQ-037 Store lanes: mem_wdata = req_wdata shifted left by 8*addr[low bits]; mem_wstrb = ((1<<bytes)-1) << offset.
REQ-038 Loads SHALL drive mem_wstrb=0.
REQ-039 Load: resp_rdata = mem_rdata shifted right by 8*offset, truncated to the size, then sign- or zero-extended to DATA_WIDTH.
REQ-040 A store completes on mem_rvalid (write acknowledge), with resp_rdata=0.
REQ-041 Counter width SHALL be clog2(TIMEOUT+1); the counter SHALL clear on entry to BUS.

Reset
REQ-042 When rst is low, SHALL asynchronously go to state IDLE and clear the counter and all registered request and response fields.
REQ-043 Output reset values SHALL be: req_ready=1, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-044 Reset asserted mid-access SHALL abandon the access with no response; a bus beat that arrives after reset SHALL be ignored.

Structure
REQ-045 Size codes, error codes and FSM state encodings SHALL be defined as constants in the shared config/inst include, next to the existing ISA_WIDTH.
REQ-046 Lane shifting, strobe generation and load extension SHALL sit in one combinational sub-module, lsu_align, reused for the store and load paths.

Verification
REQ-047 Load byte signed: addr=0x8000_0003, mem_rdata=0x80FF_FFFF, 0-cycle memory -> resp_rdata=0xFFFF_FF80, err=0, latency 2.
REQ-048 Store half: addr=0x8000_0002, wdata=0x1234_ABCD -> mem_addr=0x8000_0000, mem_wdata=0xABCD_0000, wstrb=4'b1100.
REQ-049 Misaligned word load: addr=0x8000_0001 -> err=1, mem_valid never asserted, resp_valid in cycle 2.
REQ-050 Timeout: TIMEOUT=4, mem_ready=1, no mem_rvalid -> err=2 after 4 wait cycles; a later mem_rvalid is ignored.
REQ-051 Backpressure: mem_ready held low 3 cycles and resp_ready held low 2 cycles -> bus outputs and response stable throughout; exactly one completion.
REQ-052 Reset in WAIT: rst low for 1 cycle -> IDLE, resp_valid=0, next request serviced normally.
